instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the 64-bit PC and drives it to the combinational instruction memory, whose instruction is valid in the same cycle.
- Captures each {pc, instruction} pair into a small FIFO and presents it to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute and flags fetches outside the memory range.

Parameters:
- RESET_PC, 64'h0, PC value after reset.
- FQ_DEPTH, 2, fetch-queue entries (power of 2, ≥2).
- MEM_WORDS, 128, number of 32-bit words in instruction memory; legal word index is 0..MEM_WORDS-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_pc  out  64  fetch address to instruction memory; always equals pc_q.
- imem_instr  in  32  instruction returned combinationally for imem_pc.
- if_valid  out  1  queue head is valid.
- if_pc  out  64  PC of queue head.
- if_instr  out  32  instruction of queue head.
- id_ready  in  1  decode accepts head; pop occurs when if_valid && id_ready.
- redirect_valid  in  1  execute requests a PC change (taken branch, jal, jalr).
- redirect_pc  in  64  target PC.
- if_fault  out  1  sticky: fetch PC word index ≥ MEM_WORDS.

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc_q = RESET_PC; queue count = 0; read/write pointers = 0; if_fault = 0.
  - if_valid = 0; if_pc = 0; if_instr = 0.
  - All in-flight entries are discarded.
- Fetch, evaluated every cycle with no redirect and no fault:
  - push = (count < FQ_DEPTH) || pop.
  - On push: write {pc_q, imem_instr} at wr_ptr, then pc_q += 4.
  - When push is blocked, pc_q holds and imem_pc is stable.
- Latency: the instruction at PC p is visible on if_valid/if_instr in the cycle after pc_q == p, provided the queue was not blocking. With id_ready held high the sustained throughput is 1 instruction/cycle.
- Pop: on if_valid && id_ready, rd_ptr advances. if_pc/if_instr are driven from the queue head (registered storage); they are 0 when the queue is empty.
- Count update:
  - count_next = count + push − pop.
  - Simultaneous push and pop at full (FQ_DEPTH) keeps count at FQ_DEPTH.
  - Pop when empty is impossible, since if_valid = 0.
- Pointers: log2(FQ_DEPTH) bits; wrap modulo FQ_DEPTH.
- Redirect (redirect_valid = 1), which has priority over everything except reset:
  - Queue flushed: count = 0 and rd_ptr = wr_ptr.
  - A simultaneous pop is ignored.
  - No push this cycle; the stale-PC instruction is discarded.
  - pc_q = {redirect_pc[63:2], 2'b00}; low bits are forced to zero.
  - if_fault cleared.
  - if_valid = 0 in the next cycle. The target instruction appears 2 cycles after redirect_valid is asserted.
  - Back-to-back redirects: the last one wins, and each flushes.
- Fault:
  - If (pc_q >> 2) ≥ MEM_WORDS in a cycle where push would occur: nothing is pushed, if_fault is set, pc_q holds.
  - Fetch stalls until a redirect or reset.
  - Entries already queued still drain normally to decode.
- PC arithmetic: 64-bit and unsigned. Wrap at 2^64 is allowed, but it is caught by the fault check first.
- The block never writes instruction memory; imem_pc is purely a function of pc_q.

Decomposition:
- Shared package rv_fetch_pkg:
  - XLEN = 64; ILEN = 32.
  - Type fetch_entry_t = {pc[63:0], instr[31:0]}.
  - Constants NOP_INSTR = 32'h00000013 and PC_STEP = 4.
- One natural sub-module: fetch_fifo. It is a parameterized sync FIFO of fetch_entry_t with push/pop/flush, count, full, and empty, plus async active-high reset.
- The top level holds pc_q, the fault flag, and push/redirect control.

Test Plan:
- Reset, RESET_PC = 0, memory words 0..3 = 0xfd010113, 0x02812623, 0x03010413, 0x12400793, id_ready = 1 → if_valid rises in cycle 1. Decode sees pc 0, 4, 8, 12 with those words on consecutive cycles.
- id_ready = 0 from reset for 5 cycles → queue fills at 2 entries (pc 0 and 4). pc_q holds at 8 and imem_pc stays 8. On release, decode sees 0, 4, 8 with no gaps or duplicates.
- Redirect in a cycle with queue full and id_ready = 1, redirect_pc = 0x3e → queue flushed and the pop is ignored. if_valid = 0 next cycle. The following cycle, if_pc = 0x3c and if_instr = mem[15].
- Sequential fetch reaches pc = 0x1fc (word 127, last legal), then 0x200 → word 127 is delivered. if_fault = 1 with pc_q held at 0x200, and no further pushes. A redirect to 0x40 clears the fault and fetch resumes at word 16.
- Assert rst asynchronously mid-cycle while the queue holds 2 entries → if_valid, if_pc, if_instr, and if_fault go to 0 immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
- Redirect on two consecutive cycles, to 0x10 then 0x20 → only pc 0x20 and its successors are ever presented to decode.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared widths, fetch-queue entry type and fetch constants.
package rv_fetch_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;
  localparam logic [XLEN-1:0] PC_STEP = 64'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of fetch entries with flush; head reads as zero when empty.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner feeding decode through a small fetch queue with redirect and range fault.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          FQ_DEPTH  = 2,
  parameter int          MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_fault
);
  logic [63:0] pc_q;
  logic fault_q, fq_full, fq_empty, pop, can_push, oob, push;
  fetch_entry_t head;
  assign imem_pc = pc_q;
  assign if_fault = fault_q;
  assign if_valid = !fq_empty;
  assign if_pc = head.pc;
  assign if_instr = head.instr;
  assign pop = if_valid && id_ready;
  assign can_push = !fq_full || pop;
  assign oob = (pc_q >> 2) >= 64'(MEM_WORDS);
  assign push = !redirect_valid && !fault_q && can_push && !oob;
  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: pc_q, instr: imem_instr}),
    .dout  (head),
    .full  (fq_full),
    .empty (fq_empty)
  );
  // A fault only latches when a push was actually due, so a blocked queue never faults early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[63:2], 2'b00};
      fault_q <= 1'b0;
    end else if (push) begin
      pc_q <= pc_q + PC_STEP;
    end else if (!fault_q && can_push && oob) begin
      fault_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of instr_fetch_unit against a queue-based model.
module tb_instr_fetch_unit;
  import rv_fetch_pkg::*;
  localparam int DEPTH = 2;
  localparam int WORDS = 128;
  logic clk = 1'b0;
  logic rst, if_valid, id_ready, redirect_valid, if_fault;
  logic [63:0] imem_pc, if_pc, redirect_pc;
  logic [31:0] imem_instr, if_instr;
  logic [31:0] mem [WORDS];
  logic [63:0] m_pc;
  bit m_fault;
  fetch_entry_t m_q[$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;
  assign imem_instr = (imem_pc >> 2) < 64'(WORDS) ? mem[imem_pc[8:2]] : 32'hdeadbeef;

  instr_fetch_unit #(.RESET_PC(64'h0), .FQ_DEPTH(DEPTH), .MEM_WORDS(WORDS)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_fault       (if_fault)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit v;
    v = m_q.size() > 0;
    chk("if_valid", if_valid, v);
    chk("if_pc", if_pc, v ? m_q[0].pc : 64'h0);
    chk("if_instr", if_instr, v ? 64'(m_q[0].instr) : 64'h0);
    chk("imem_pc", imem_pc, m_pc);
    chk("if_fault", if_fault, m_fault);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 64'h0;
    m_fault = 0;
  endtask

  // Queue semantics: drop head on accept, then fetch if a slot is free.
  task automatic model_edge();
    if (redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[63:2], 2'b00};
      m_fault = 0;
    end else begin
      if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
      if (m_q.size() < DEPTH && !m_fault) begin
        if (m_pc / 4 >= 64'(WORDS)) m_fault = 1;
        else begin
          m_q.push_back('{pc: m_pc, instr: mem[m_pc[8:2]]});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w [4];
    w = '{32'hfd010113, 32'h02812623, 32'h03010413, 32'h12400793};
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = w[i];
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("seq_valid", if_valid, 1);
      chk("seq_pc", if_pc, 64'(4 * i));
      chk("seq_instr", if_instr, 64'(w[i]));
    end
    do_reset();
    id_ready = 1'b0;
    repeat (5) cycle();
    chk("stall_imem_pc", imem_pc, 64'h8);
    chk("stall_head", if_pc, 64'h0);
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("release_pc", if_pc, 64'(4 * i));
      cycle();
    end
    do_reset();
    id_ready = 1'b0;
    repeat (3) cycle();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h3e;
    cycle();
    chk("redir_flush", if_valid, 0);
    redirect_valid = 1'b0;
    cycle();
    chk("redir_pc", if_pc, 64'h3c);
    chk("redir_instr", if_instr, 64'(mem[15]));
    redirect_valid = 1'b1;
    redirect_pc = 64'h1f0;
    cycle();
    redirect_valid = 1'b0;
    repeat (4) cycle();
    chk("last_word_pc", if_pc, 64'h1fc);
    chk("last_word_instr", if_instr, 64'(mem[127]));
    repeat (3) cycle();
    chk("fault_set", if_fault, 1);
    chk("fault_hold_pc", imem_pc, 64'h200);
    chk("fault_empty", if_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    cycle();
    chk("fault_clear", if_fault, 0);
    redirect_valid = 1'b0;
    cycle();
    chk("resume_pc", if_pc, 64'h40);
    chk("resume_instr", if_instr, 64'(mem[16]));
    redirect_valid = 1'b1;
    redirect_pc = 64'h1fc;
    cycle();
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    repeat (4) cycle();
    chk("pre_async_fault", if_fault, 1);
    chk("pre_async_valid", if_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", if_valid, 0);
    chk("async_pc", if_pc, 64'h0);
    chk("async_instr", if_instr, 64'h0);
    chk("async_fault", if_fault, 0);
    model_reset();
    compare();
    @(negedge clk);
    rst = 1'b0;
    id_ready = 1'b1;
    cycle();
    chk("restart_pc", if_pc, 64'h0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h10;
    cycle();
    redirect_pc = 64'h20;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("b2b_pc", if_pc, 64'h20);
    repeat (4) cycle();
    for (int n = 0; n < 2000; n++) begin
      id_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc = {$urandom, $urandom} & 64'h0 | 64'(($urandom_range(0, 140) * 4) + ($urandom % 4));
      if ($urandom % 250 == 0) do_reset();
      else cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
